// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: IDLE -> BUSY x LATENCY -> DONE per access.
// Optional misalignment detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] MemoryData_o,
    output logic        valid_o,
    output logic        err_o
);
    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0]   idx_reg;
    logic [31:0]            wdata_reg;
    logic                   rd_reg, wr_reg, mis_reg;
    logic [31:0]            rdata_reg;
    logic                   err_reg;
    logic                   req;
    logic                   capture;
    logic                   access_fire;
    logic                   mis_in;
    logic                   unused_addr_bits;

    logic [31:0] mem [DEPTH_WORDS];

    assign req         = MemRead_i | MemWrite_i;
    assign capture     = (state_reg == IDLE) && req;
    assign access_fire = (state_reg == BUSY) && (cnt_reg == 4'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_in = |addr_i[1:0];
`else
    assign mis_in = 1'b0;
`endif

    // Upper address bits wrap the array; byte offset only matters for the misalignment check.
    assign unused_addr_bits = ^{addr_i[31:ADDR_BITS+2], addr_i[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall_o    = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_reg   <= '0;
            wdata_reg <= 32'd0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            mis_reg   <= 1'b0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            if (capture) begin
                idx_reg   <= addr_i[ADDR_BITS+1:2];
                wdata_reg <= wdata_i;
                rd_reg    <= MemRead_i;
                wr_reg    <= MemWrite_i;
                mis_reg   <= mis_in;
            end
            // Read and write share the edge; the non-blocking read returns the pre-write word.
            if (access_fire && rd_reg) begin
                rdata_reg <= mis_reg ? 32'd0 : mem[idx_reg];
            end
            err_reg <= access_fire && mis_reg;
        end
    end

    // Array has no reset; an aborted access never reaches access_fire because reset forces IDLE.
    always_ff @(posedge clk_i) begin
        if (access_fire && wr_reg && !mis_reg) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

    assign MemoryData_o = rdata_reg;
    assign valid_o      = (state_reg == DONE);
    assign err_o        = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a transaction-level timeline model sets per-cycle expectations,
// one compare process checks every cycle, literal pins anchor the model. Honors DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        stall_o;
    logic [31:0] MemoryData_o;
    logic        valid_o;
    logic        err_o;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
        .MemoryData_o(MemoryData_o), .valid_o(valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];
    logic        exp_stall = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_data  = 32'd0;
    logic        cmp_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
            chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
            chk("err_o", {31'd0, err_o}, {31'd0, exp_err});
            chk("MemoryData_o", MemoryData_o, exp_data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        exp_stall  = 1'b0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // One access spans LAT+2 cycles: stalled for LAT+1, then a DONE cycle carrying valid/err/data.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int          idx;
        logic        mis;
        logic [31:0] rdv;
        idx = int'((a >> 2) % DEPTH);
        mis = MIS_EN && (a % 4 != 0);
        rdv = mis ? 32'd0 : model_mem[idx];
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        for (int k = 0; k <= LAT + 1; k++) begin
            exp_stall = (k <= LAT);
            exp_valid = (k == LAT + 1);
            exp_err   = (k == LAT + 1) && mis;
            if (k == LAT + 1 && rd) exp_data = rdv;
            next_cycle();
        end
        if (wr && !mis) model_mem[idx] = wd;
        $display("access rd=%0b wr=%0b addr=%h wdata=%h -> data=%h", rd, wr, a, wd, MemoryData_o);
    endtask

    initial begin
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        next_cycle();
        rst_i = 1'b1;
        idle(1);

        // Store leaves load data untouched, then load returns it.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("store_keeps_data", MemoryData_o, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        chk("load_0x10", MemoryData_o, 32'hDEADBEEF);
        idle(1);

        // Address wrap: 0x400 aliases word 0.
        access(1'b0, 1'b1, 32'h400, 32'h12345678);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        chk("wrap_load_0x000", MemoryData_o, 32'h12345678);

        // Simultaneous read+write returns the pre-write word.
        access(1'b0, 1'b1, 32'h20, 32'h1);
        access(1'b1, 1'b1, 32'h20, 32'h2);
        chk("rw_old_word", MemoryData_o, 32'h1);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        chk("rw_new_word", MemoryData_o, 32'h2);
        idle(2);

        // Reset during BUSY before the write edge aborts the store.
        access(1'b0, 1'b1, 32'h30, 32'h0BAD0030);
        MemWrite_i = 1'b1;
        addr_i     = 32'h30;
        wdata_i    = 32'hAAAA5555;
        exp_stall  = 1'b1;
        exp_valid  = 1'b0;
        next_cycle();
        next_cycle();
        rst_i      = 1'b0;
        MemWrite_i = 1'b0;
        exp_stall  = 1'b0;
        exp_data   = 32'd0;
        next_cycle();
        chk("reset_data", MemoryData_o, 32'h0);
        rst_i = 1'b1;
        next_cycle();
        $display("reset abort of store 0xAAAA5555 to 0x30 -> data=%h", MemoryData_o);
        access(1'b1, 1'b0, 32'h30, 32'h0);
        chk("abort_no_write", MemoryData_o, 32'h0BAD0030);

        // Back-to-back loads: valid pulses LAT+2 cycles apart.
        access(1'b1, 1'b0, 32'h10, 32'h0);
        chk("b2b_first", MemoryData_o, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h400, 32'h0);
        chk("b2b_second", MemoryData_o, 32'h12345678);

        // Misaligned load and store.
        access(1'b1, 1'b0, 32'h13, 32'h0);
        chk("misaligned_load", MemoryData_o, MIS_EN ? 32'h0 : 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h12, 32'h00000055);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        chk("misaligned_store", MemoryData_o, MIS_EN ? 32'hDEADBEEF : 32'h00000055);
        idle(2);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
